// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard unit.
// Tags are sized for the widest supported configuration; narrower builds zero-extend.
package fwd_pkg;
  localparam int SRC_MAX      = 4;
  localparam int AW_MAX       = 8;
  localparam int FWD_REGFILE  = 0;
  localparam int ZERO_REG_DEF = 31;

  typedef struct packed {
    logic                             valid;
    logic [AW_MAX-1:0]                rd;
    logic                             regwrite;
    logic                             memread;
    logic [SRC_MAX-1:0][AW_MAX-1:0]   src;
    logic [SRC_MAX-1:0]               srcUsed;
  } tag_t;

  function automatic logic tagWrites(input tag_t t, input logic [AW_MAX-1:0] zeroReg);
    return t.valid && t.regwrite && (t.rd != zeroReg);
  endfunction
endpackage

// File: rtl/fwd_operand_select.sv
// Per-operand forward select: youngest post-EX stage writing the operand's register wins.
module fwd_operand_select
  import fwd_pkg::*;
#(
  parameter int FWD_DEPTH = 2,
  parameter int REG_AW    = 5,
  parameter int ZERO_REG  = ZERO_REG_DEF,
  parameter int W         = $clog2(FWD_DEPTH + 1)
) (
  input  logic                    srcValid,
  input  logic                    srcUsed,
  input  logic [REG_AW-1:0]       src,
  input  tag_t [FWD_DEPTH-1:0]    stages,
  output logic [W-1:0]            sel
);
  localparam logic [AW_MAX-1:0] ZR = AW_MAX'(ZERO_REG);

  logic [AW_MAX-1:0] srcExt;
  logic              unusedStages;

  assign srcExt       = AW_MAX'(src);
  assign unusedStages = ^stages;

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    sel = W'(FWD_REGFILE);
    if (srcValid && srcUsed && srcExt != ZR) begin
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        if (tagWrites(stages[k-1], ZR) && stages[k-1].rd == srcExt) sel = W'(k);
      end
    end
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// Destination-tag pipeline driving EX operand forward selects, load-use stall and stall counter.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int REG_AW    = 5,
  parameter int ZERO_REG  = ZERO_REG_DEF,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int CNT_W     = 32
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]                 id_src,
  input  logic [NUM_SRC-1:0]                        id_src_used,
  input  logic [REG_AW-1:0]                         id_rd,
  input  logic                                      id_regwrite,
  input  logic                                      id_memread,
  input  logic                                      flush,
  output logic [NUM_SRC*$clog2(FWD_DEPTH+1)-1:0]    fwd_sel,
  output logic                                      stall,
  output logic [CNT_W-1:0]                          stall_count
);
  localparam int W = $clog2(FWD_DEPTH + 1);
  localparam logic [AW_MAX-1:0] ZR = AW_MAX'(ZERO_REG);

  tag_t [FWD_DEPTH:0]                tags;
  tag_t                              idTag;
  logic [NUM_SRC-1:0][AW_MAX-1:0]    idSrc;
  logic                              unusedTags;

  assign unusedTags = ^tags;

  always_comb begin
    idSrc = '0;
    for (int i = 0; i < NUM_SRC; i++) idSrc[i] = AW_MAX'(id_src[i*REG_AW +: REG_AW]);
  end

  // Only loads still short of LOAD_LAT stages past EX can't be forwarded yet.
  always_comb begin
    stall = 1'b0;
    if (id_valid && !flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        for (int k = 0; k < LOAD_LAT; k++) begin
          if (id_src_used[i] && idSrc[i] != ZR && tagWrites(tags[k], ZR) &&
              tags[k].memread && tags[k].rd == idSrc[i])
            stall = 1'b1;
        end
      end
    end
  end

  always_comb begin
    idTag          = '0;
    idTag.valid    = id_valid && !flush && !stall;
    idTag.rd       = AW_MAX'(id_rd);
    idTag.regwrite = id_regwrite;
    idTag.memread  = id_memread;
    for (int i = 0; i < NUM_SRC; i++) begin
      idTag.src[i]     = idSrc[i];
      idTag.srcUsed[i] = id_src_used[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tags        <= '0;
      stall_count <= '0;
    end else begin
      tags[0] <= idTag;
      for (int k = 1; k <= FWD_DEPTH; k++) tags[k] <= tags[k-1];
      if (stall && stall_count != {CNT_W{1'b1}}) stall_count <= stall_count + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : gSel
    fwd_operand_select #(
      .FWD_DEPTH(FWD_DEPTH),
      .REG_AW   (REG_AW),
      .ZERO_REG (ZERO_REG),
      .W        (W)
    ) uSel (
      .srcValid(tags[0].valid),
      .srcUsed (tags[0].srcUsed[i]),
      .src     (tags[0].src[i][REG_AW-1:0]),
      .stages  (tags[FWD_DEPTH:1]),
      .sel     (fwd_sel[i*W +: W])
    );
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: default build (A), LOAD_LAT=2 build (B), CNT_W=4 build (C) on shared stimulus.
module tb_fwd_hazard_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [9:0] id_src;
  logic [1:0] id_src_used;
  logic [4:0] id_rd;
  logic       id_regwrite, id_memread, flush;

  logic [3:0]  selA, selB, selC;
  logic        stallA, stallB, stallC;
  logic [31:0] cntA, cntB;
  logic [3:0]  cntC;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit uA (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .fwd_sel(selA), .stall(stallA), .stall_count(cntA));

  fwd_hazard_unit #(.LOAD_LAT(2)) uB (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .fwd_sel(selB), .stall(stallB), .stall_count(cntB));

  fwd_hazard_unit #(.CNT_W(4)) uC (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .fwd_sel(selC), .stall(stallC), .stall_count(cntC));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setId(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] u, input logic [4:0] rd, input logic rw, input logic mr);
    id_valid    = v;
    id_src      = {s1, s0};
    id_src_used = u;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    #1;
  endtask

  task automatic bubble();
    setId(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bubble();
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("reset_sel", 32'(selA), 32'd0);
    chk("reset_stall", 32'(stallA), 32'd0);
    chk("reset_count", cntA, 32'd0);

    // back-to-back ALU dependency
    setId(1'b1, 5'd2, 5'd3, 2'b11, 5'd1, 1'b1, 1'b0);
    chk("alu_prod_stall", 32'(stallA), 32'd0);
    tick();
    setId(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0);
    chk("alu_cons_stall", 32'(stallA), 32'd0);
    tick();
    chk("alu_sel0", 32'(selA[1:0]), 32'd1);
    chk("alu_sel1", 32'(selA[3:2]), 32'd0);

    // two writers of X3: younger wins
    setId(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0); tick();
    setId(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0); tick();
    setId(1'b1, 5'd3, 5'd9, 2'b11, 5'd10, 1'b1, 1'b0); tick();
    chk("dbl_sel0_young", 32'(selA[1:0]), 32'd1);
    chk("dbl_sel1_none", 32'(selA[3:2]), 32'd0);
    // distance-2 producer
    setId(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0); tick();
    setId(1'b1, 5'd0, 5'd0, 2'b00, 5'd12, 1'b1, 1'b0); tick();
    setId(1'b1, 5'd7, 5'd3, 2'b11, 5'd13, 1'b1, 1'b0); tick();
    chk("dist2_sel1", 32'(selA[3:2]), 32'd2);
    chk("dist2_sel0", 32'(selA[1:0]), 32'd0);

    // load-use
    setId(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b1); tick();
    setId(1'b1, 5'd4, 5'd5, 2'b11, 5'd6, 1'b1, 1'b0);
    chk("lu_stall_A", 32'(stallA), 32'd1);
    chk("lu_stall_B", 32'(stallB), 32'd1);
    tick();
    chk("lu_stall_A_c2", 32'(stallA), 32'd0);
    chk("lu_stall_B_c2", 32'(stallB), 32'd1);
    chk("lu_ex_bubble", 32'(selA[1:0]), 32'd0);
    chk("lu_count_A", cntA, 32'd1);
    tick();
    chk("lu_sel0_A", 32'(selA[1:0]), 32'd2);
    chk("lu_stall_B_c3", 32'(stallB), 32'd0);
    chk("lu_count_B", cntB, 32'd2);
    bubble(); tick();
    chk("lu_count_A_hold", cntA, 32'd1);

    // XZR load and XZR operands
    setId(1'b1, 5'd0, 5'd0, 2'b00, 5'd31, 1'b1, 1'b1); tick();
    setId(1'b1, 5'd31, 5'd31, 2'b11, 5'd20, 1'b1, 1'b0);
    chk("xzr_stall", 32'(stallA), 32'd0);
    tick();
    chk("xzr_sel0", 32'(selA[1:0]), 32'd0);
    chk("xzr_sel1", 32'(selA[3:2]), 32'd0);
    // unused operand matching a pending load
    setId(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1); tick();
    setId(1'b1, 5'd8, 5'd7, 2'b01, 5'd21, 1'b1, 1'b0);
    chk("unused_stall", 32'(stallA), 32'd0);
    tick();
    chk("unused_sel1", 32'(selA[3:2]), 32'd0);
    chk("unused_count", cntA, 32'd1);

    // flush beats load-use stall
    setId(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b1); tick();
    setId(1'b1, 5'd4, 5'd4, 2'b11, 5'd6, 1'b1, 1'b0);
    flush = 1'b1; #1;
    chk("flush_stall", 32'(stallA), 32'd0);
    tick();
    flush = 1'b0;
    bubble();
    chk("flush_sel", 32'(selA), 32'd0);
    chk("flush_count", cntA, 32'd1);

    // reset with a load in flight and a stall pending
    setId(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b1); tick();
    setId(1'b1, 5'd4, 5'd2, 2'b11, 5'd6, 1'b1, 1'b0);
    chk("prerst_stall", 32'(stallA), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    chk("rst_stall", 32'(stallA), 32'd0);
    chk("rst_sel", 32'(selA), 32'd0);
    chk("rst_count", cntA, 32'd0);
    bubble(); tick();

    // saturation of the 4-bit counter
    for (int n = 1; n <= 16; n++) begin
      setId(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b1); tick();
      setId(1'b1, 5'd4, 5'd1, 2'b11, 5'd6, 1'b1, 1'b0);
      if (n == 16) chk("sat_stall", 32'(stallC), 32'd1);
      tick(); tick();
      if (n == 15) chk("sat_count15", 32'(cntC), 32'd15);
    end
    chk("sat_hold", 32'(cntC), 32'd15);
    chk("sat_wide_count", cntA, 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
